tcdm_bank_ts_adapter: RTL and testbench
=======================================

# tcdm_bank_ts_adapter

Per-bank adapter between one memory-side port of the cluster TCDM interconnect and one single-port SRAM bank macro with 1-cycle read latency. Passes plain reads and writes straight through and returns a 1-cycle response. Executes test-and-set reads as an atomic two-cycle read-modify-write, stalling the port for the write-back cycle. Keeps a saturating stall counter for performance monitoring. One instance sits on each of the NB_TCDM_BANKS interconnect memory ports, directly downstream of the interconnect.

## Interface
- DW, 32, data width (bits)
- AW, 13, request address width (bank-local word address plus test-and-set flag)
- MEM_AW, 11, SRAM word-address width; MEM_AW < AW
- TS_BIT, 12, bit of add_i that flags test-and-set; MEM_AW <= TS_BIT < AW
- IW, 8, transaction ID width
- CNT_W, 16, stall counter width
- clk_i  in  1  clock; everything is sampled on its rising edge
- rst_i  in  1  synchronous, active-high reset
- clear_i  in  1  synchronous clear of the stall counter only
- req_i  in  1  request valid from interconnect
- gnt_o  out  1  request accepted this cycle
- add_i  in  AW  word address; bit TS_BIT selects test-and-set
- wen_i  in  1  1 = read, 0 = write
- data_i  in  DW  write data
- be_i  in  DW/8  byte enables
- id_i  in  IW  transaction ID
- r_valid_o  out  1  response valid
- r_data_o  out  DW  response data
- r_id_o  out  IW  response ID
- mem_req_o  out  1  SRAM chip enable
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  MEM_AW  SRAM word address
- mem_wdata_o  out  DW  SRAM write data
- mem_be_o  out  DW/8  SRAM byte enables
- mem_rdata_i  in  DW  SRAM read data, valid the cycle after a read
- stall_cnt_o  out  CNT_W  count of cycles with req_i=1 and gnt_o=0

## Operation
- FSM with two states:
  - IDLE: gnt_o = req_i.
  - TS_WB: gnt_o = 0.
  - IDLE→TS_WB when a granted request has wen_i=1 and add_i[TS_BIT]=1.
  - TS_WB→IDLE always after one cycle.
- Granted request in IDLE:
  - SRAM outputs are driven combinationally the same cycle.
  - mem_req_o=1, mem_we_o=~wen_i, mem_addr_o=add_i[MEM_AW-1:0], mem_wdata_o=data_i, mem_be_o=be_i.
- Write with add_i[TS_BIT]=1: treated as a plain write; the flag is ignored.
- TS_WB cycle:
  - mem_req_o=1, mem_we_o=1, mem_be_o all ones, mem_wdata_o all ones.
  - mem_addr_o is the address registered from the test-and-set request.
- Response: every granted request, reads and writes, produces exactly one response.
  - Response is in the next cycle: r_valid_o=1 and r_id_o = registered id_i.
  - Reads and test-and-set: r_data_o = mem_rdata_i, passed through combinationally. For test-and-set this is the pre-write (old) value.
  - Writes: r_data_o = 0.
  - No response backpressure.
- No granted request and not in TS_WB: mem_req_o=0. Data, address and byte-enable outputs are don't-care but deterministic (driven from the inputs).
- stall_cnt_o:
  - Increments on each cycle with req_i & ~gnt_o.
  - Saturates at 2^CNT_W-1.
  - clear_i has priority over increment.

## Timing
- Reset values: state IDLE, gnt_o=0, mem_req_o=0, r_valid_o=0, r_data_o=0, r_id_o=0, stall_cnt_o=0.
- gnt_o is forced 0 while rst_i=1.
- Response latency is 1 cycle for every request type. Test-and-set occupies the bank for 2 cycles.
- Maximum throughput is 1 request per cycle for plain reads and writes.
- Back-to-back test-and-set requests to the same bank are granted at t, t+2, t+4, and so on.
- A request after test-and-set at t is granted at t+2 and observes the all-ones write, because the SRAM write at t+1 has already completed.
- Reset asserted during TS_WB: the write-back is aborted (mem_req_o=0 that cycle) and the pending response is dropped (r_valid_o=0 next cycle).
- req_i is not required to be held while gnt_o=0. The interconnect keeps it asserted, and the adapter has no memory of ungranted requests.

## Test plan
- Reset: hold rst_i 3 cycles with req_i=1 -> gnt_o=0, mem_req_o=0, r_valid_o=0, stall_cnt_o=0 on every cycle.
- Plain write then read: write 0xDEADBEEF to word 5 with be=0xF and id=3, then read word 5 with id=4 -> gnt_o=1 both cycles; responses at t+1 (data 0, id 3) and t+2 (data 0xDEADBEEF, id 4).
- Partial write: word 7 holds 0x11223344; write 0xAABBCCDD with be=0x3, then read -> 0x1122CCDD.
- Test-and-set: word 9 = 0 -> r_data_o=0 at t+1; at t+1 mem_we_o=1, mem_addr_o=9, mem_wdata_o=0xFFFFFFFF, gnt_o=0; a second test-and-set at t+2 returns 0xFFFFFFFF.
- Stall counter: 4 back-to-back test-and-set requests with req_i held high -> stall_cnt_o=3; then clear_i with a simultaneous stall -> stall_cnt_o=0; with CNT_W=2 it saturates at 3.
- Reset mid-operation: assert rst_i in the TS_WB cycle -> mem_req_o=0, word unchanged on a later read, no response emitted.

Source files
------------

// File: rtl/tcdm_bank_ts_adapter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tcdm_bank_ts_adapter : TCDM bank port adapter with atomic test-and-set
// Rev 1.0
// ---------------------------------------------------------------------------
module tcdm_bank_ts_adapter #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 13,
  parameter int unsigned MEM_AW = 11,
  parameter int unsigned TS_BIT = 12,
  parameter int unsigned IW     = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [AW-1:0]     add_i,
  input  logic              wen_i,
  input  logic [DW-1:0]     data_i,
  input  logic [DW/8-1:0]   be_i,
  input  logic [IW-1:0]     id_i,
  output logic              r_valid_o,
  output logic [DW-1:0]     r_data_o,
  output logic [IW-1:0]     r_id_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic [DW/8-1:0]   mem_be_o,
  input  logic [DW-1:0]     mem_rdata_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] TS_WB = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]        state_q, state_d;
  logic [MEM_AW-1:0] ts_addr_q;
  logic              r_valid_q;
  logic              r_read_q;
  logic [IW-1:0]     r_id_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic in_wb;
  logic is_ts;
  logic stall;
  logic unused_add;

  // Only the word address and the test-and-set flag carry meaning.
  assign unused_add = ^add_i[AW-1:MEM_AW];

  assign in_wb = (state_q == TS_WB);
  assign is_ts = wen_i & add_i[TS_BIT];
  assign gnt_o = req_i & ~in_wb & ~rst_i;
  assign stall = req_i & ~gnt_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_o && is_ts) state_d = TS_WB;
      TS_WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-back of the all-ones flag takes over the SRAM port; reset aborts it.
  always_comb begin
    mem_req_o   = gnt_o;
    mem_we_o    = ~wen_i;
    mem_addr_o  = add_i[MEM_AW-1:0];
    mem_wdata_o = data_i;
    mem_be_o    = be_i;
    if (in_wb) begin
      mem_req_o   = ~rst_i;
      mem_we_o    = 1'b1;
      mem_addr_o  = ts_addr_q;
      mem_wdata_o = '1;
      mem_be_o    = '1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (stall && (cnt_q != '1))
      cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ts_addr_q <= '0;
      r_valid_q <= 1'b0;
      r_read_q  <= 1'b0;
      r_id_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      r_valid_q <= gnt_o;
      cnt_q     <= cnt_d;
      if (gnt_o) begin
        r_read_q <= wen_i;
        r_id_q   <= id_i;
      end
      if (gnt_o && is_ts)
        ts_addr_q <= add_i[MEM_AW-1:0];
    end
  end

  assign r_valid_o   = r_valid_q & ~rst_i;
  assign r_data_o    = (r_valid_o && r_read_q) ? mem_rdata_i : '0;
  assign r_id_o      = r_id_q;
  assign stall_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tcdm_bank_ts_adapter.sv
`default_nettype none
// Directed bench for tcdm_bank_ts_adapter with a 1-cycle-latency SRAM model.
module tb_tcdm_bank_ts_adapter;

  logic        clk = 1'b0;
  logic        rst, clear, req, wen;
  logic [12:0] add;
  logic [31:0] data;
  logic [3:0]  be;
  logic [7:0]  id;

  logic        gnt, r_valid, mem_req, mem_we;
  logic [31:0] r_data, mem_wdata;
  logic [7:0]  r_id;
  logic [10:0] mem_addr;
  logic [3:0]  mem_be;
  logic [15:0] stall_cnt;

  logic        gnt2, r_valid2, mem_req2, mem_we2;
  logic [31:0] r_data2, mem_wdata2;
  logic [7:0]  r_id2;
  logic [10:0] mem_addr2;
  logic [3:0]  mem_be2;
  logic [1:0]  stall_cnt2;

  logic [31:0] mem [0:2047];
  logic [31:0] rdata_q;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [12:0] TSF = 13'h1000;

  always #5 clk = ~clk;

  tcdm_bank_ts_adapter dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .req_i(req), .gnt_o(gnt),
    .add_i(add), .wen_i(wen), .data_i(data), .be_i(be), .id_i(id),
    .r_valid_o(r_valid), .r_data_o(r_data), .r_id_o(r_id),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(rdata_q),
    .stall_cnt_o(stall_cnt)
  );

  tcdm_bank_ts_adapter #(.CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .req_i(req), .gnt_o(gnt2),
    .add_i(add), .wen_i(wen), .data_i(data), .be_i(be), .id_i(id),
    .r_valid_o(r_valid2), .r_data_o(r_data2), .r_id_o(r_id2),
    .mem_req_o(mem_req2), .mem_we_o(mem_we2), .mem_addr_o(mem_addr2),
    .mem_wdata_o(mem_wdata2), .mem_be_o(mem_be2), .mem_rdata_i(rdata_q),
    .stall_cnt_o(stall_cnt2)
  );

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        rdata_q <= mem[mem_addr];
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input logic r, input logic w, input logic [12:0] a,
                         input logic [31:0] d, input logic [3:0] b, input logic [7:0] i);
    req = r; wen = w; add = a; data = d; be = b; id = i;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0;
    set_req(1'b1, 1'b1, TSF, 32'h0, 4'h0, 8'h0);
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      n_tests++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt cyc %0d: got %b exp 0", k, gnt); end
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req cyc %0d: got %b exp 0", k, mem_req); end
      n_tests++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid cyc %0d: got %b exp 0", k, r_valid); end
      n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt cyc %0d: got %0d exp 0", k, stall_cnt); end
    end
    step();
    rst = 1'b0;
    set_req(1'b0, 1'b1, 13'h0, 32'h0, 4'h0, 8'h0);
  endtask

  task automatic test_write_read();
    step(); set_req(1'b1, 1'b0, 13'd5, 32'hDEADBEEF, 4'hF, 8'd3); #1;
    n_tests++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b exp 1", gnt); end
    n_tests++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 11'd5}) begin n_fail++; $display("FAIL wr_mem: got req=%b we=%b addr=%0d exp 1 1 5", mem_req, mem_we, mem_addr); end
    step(); set_req(1'b1, 1'b1, 13'd5, 32'h0, 4'hF, 8'd4); #1;
    n_tests++; if ({r_valid, r_id, r_data} !== {1'b1, 8'd3, 32'h0}) begin n_fail++; $display("FAIL wr_resp: got v=%b id=%0d data=%h exp 1 3 0", r_valid, r_id, r_data); end
    n_tests++; if ({gnt, mem_we} !== 2'b10) begin n_fail++; $display("FAIL rd_gnt_we: got gnt=%b we=%b exp 1 0", gnt, mem_we); end
    step(); set_req(1'b0, 1'b1, 13'd0, 32'h0, 4'h0, 8'd0); #1;
    n_tests++; if ({r_valid, r_id, r_data} !== {1'b1, 8'd4, 32'hDEADBEEF}) begin n_fail++; $display("FAIL rd_resp: got v=%b id=%0d data=%h exp 1 4 deadbeef", r_valid, r_id, r_data); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_mem_req: got %b exp 0", mem_req); end
    step(); #1;
    n_tests++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL idle_r_valid: got %b exp 0", r_valid); end
  endtask

  task automatic test_partial_write();
    step(); set_req(1'b1, 1'b0, 13'd7, 32'h11223344, 4'hF, 8'd1);
    step(); set_req(1'b1, 1'b0, 13'd7, 32'hAABBCCDD, 4'h3, 8'd2); #1;
    n_tests++; if (mem_be !== 4'h3) begin n_fail++; $display("FAIL partial_be: got %h exp 3", mem_be); end
    step(); set_req(1'b1, 1'b1, 13'd7, 32'h0, 4'hF, 8'd3);
    step(); set_req(1'b0, 1'b1, 13'd0, 32'h0, 4'h0, 8'd0); #1;
    n_tests++; if ({r_id, r_data} !== {8'd3, 32'h1122CCDD}) begin n_fail++; $display("FAIL partial_rd: got id=%0d data=%h exp 3 1122ccdd", r_id, r_data); end
  endtask

  task automatic test_ts();
    step(); set_req(1'b1, 1'b0, 13'd9, 32'h0, 4'hF, 8'd1);
    step(); set_req(1'b1, 1'b1, TSF | 13'd9, 32'h0, 4'h0, 8'd5); #1;
    n_tests++; if ({gnt, mem_req, mem_we} !== 3'b110) begin n_fail++; $display("FAIL ts_issue: got gnt=%b req=%b we=%b exp 1 1 0", gnt, mem_req, mem_we); end
    step(); id = 8'd6; #1;
    n_tests++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL ts_wb_gnt: got %b exp 0", gnt); end
    n_tests++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b1, 11'd9, 32'hFFFFFFFF, 4'hF}) begin n_fail++; $display("FAIL ts_wb_mem: got req=%b we=%b addr=%0d wdata=%h be=%h exp 1 1 9 ffffffff f", mem_req, mem_we, mem_addr, mem_wdata, mem_be); end
    n_tests++; if ({r_valid, r_id, r_data} !== {1'b1, 8'd5, 32'h0}) begin n_fail++; $display("FAIL ts_resp_old: got v=%b id=%0d data=%h exp 1 5 0", r_valid, r_id, r_data); end
    step(); #1;
    n_tests++; if ({gnt, r_valid} !== 2'b10) begin n_fail++; $display("FAIL ts_second_grant: got gnt=%b v=%b exp 1 0", gnt, r_valid); end
    step(); set_req(1'b0, 1'b1, 13'd0, 32'h0, 4'h0, 8'd0); #1;
    n_tests++; if ({r_valid, r_id, r_data} !== {1'b1, 8'd6, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL ts_resp_set: got v=%b id=%0d data=%h exp 1 6 ffffffff", r_valid, r_id, r_data); end
    step();
  endtask

  task automatic test_stall_counter();
    step(); clear = 1'b1;
    step(); clear = 1'b0; #1;
    n_tests++; if ({stall_cnt, stall_cnt2} !== {16'd0, 2'd0}) begin n_fail++; $display("FAIL cnt_cleared: got %0d/%0d exp 0/0", stall_cnt, stall_cnt2); end
    step(); set_req(1'b1, 1'b1, TSF | 13'd30, 32'h0, 4'h0, 8'd7);
    for (int k = 0; k < 7; k++) begin
      #1;
      n_tests++; if (gnt !== ((k % 2) == 0)) begin n_fail++; $display("FAIL b2b_gnt cyc %0d: got %b exp %b", k, gnt, (k % 2) == 0); end
      step();
    end
    #1;
    n_tests++; if ({stall_cnt, stall_cnt2} !== {16'd3, 2'd3}) begin n_fail++; $display("FAIL cnt_after_4ts: got %0d/%0d exp 3/3", stall_cnt, stall_cnt2); end
    step(); #1;
    n_tests++; if ({stall_cnt, stall_cnt2} !== {16'd4, 2'd3}) begin n_fail++; $display("FAIL cnt_saturate: got %0d/%0d exp 4/3", stall_cnt, stall_cnt2); end
    step(); clear = 1'b1; #1;
    n_tests++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL clear_stall_gnt: got %b exp 0", gnt); end
    step(); clear = 1'b0; set_req(1'b0, 1'b1, 13'd0, 32'h0, 4'h0, 8'd0); #1;
    n_tests++; if ({stall_cnt, stall_cnt2} !== {16'd0, 2'd0}) begin n_fail++; $display("FAIL clear_priority: got %0d/%0d exp 0/0", stall_cnt, stall_cnt2); end
    step();
  endtask

  task automatic test_reset_mid_ts();
    step(); set_req(1'b1, 1'b0, 13'd20, 32'h12345678, 4'hF, 8'd1);
    step(); set_req(1'b1, 1'b1, TSF | 13'd20, 32'h0, 4'h0, 8'd2);
    step(); rst = 1'b1; set_req(1'b0, 1'b1, 13'd0, 32'h0, 4'h0, 8'd0); #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstwb_mem_req: got %b exp 0", mem_req); end
    step(); rst = 1'b0; set_req(1'b1, 1'b1, 13'd20, 32'h0, 4'h0, 8'd3); #1;
    n_tests++; if ({r_valid, gnt} !== 2'b01) begin n_fail++; $display("FAIL rstwb_dropped: got v=%b gnt=%b exp 0 1", r_valid, gnt); end
    step(); set_req(1'b0, 1'b1, 13'd0, 32'h0, 4'h0, 8'd0); #1;
    n_tests++; if ({r_valid, r_data} !== {1'b1, 32'h12345678}) begin n_fail++; $display("FAIL rstwb_unchanged: got v=%b data=%h exp 1 12345678", r_valid, r_data); end
    step();
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    set_req(1'b0, 1'b1, 13'd0, 32'h0, 4'h0, 8'd0);
    test_reset();
    test_write_read();
    test_partial_write();
    test_ts();
    test_stall_counter();
    test_reset_mid_ts();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
